// File: rtl/csr_timer.sv
// csr_timer: TID/TCFG/TVAL/TICLR and the countdown timer interrupt source.
// Optional 64-bit stable counter enabled by TIMER_STABLE_CNT_EN.
module csr_timer #(
  parameter logic [31:0] CORE_ID = 32'h0,
  parameter int unsigned TIMER_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rvalue,
  output logic        timer_int,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi
);

  localparam logic [13:0] CSR_TID   = 14'h040;
  localparam logic [13:0] CSR_TCFG  = 14'h041;
  localparam logic [13:0] CSR_TVAL  = 14'h042;
  localparam logic [13:0] CSR_TICLR = 14'h044;

  localparam logic [TIMER_W-1:0] CNT_ONES = '1;
  localparam logic [TIMER_W-1:0] CNT_ZERO = '0;
  localparam logic [TIMER_W-1:0] CNT_ONE  = TIMER_W'(1);

  logic [31:0]        tid_q;
  logic [31:0]        tid_new;
  logic [TIMER_W-1:0] tcfg_q;
  logic [TIMER_W-1:0] tcfg_new;
  logic [TIMER_W-1:0] cfg_eff;
  logic [TIMER_W-1:0] reload_val;
  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;
  logic               int_q;
  logic               int_d;

  logic               tid_we;
  logic               tcfg_we;
  logic               ticlr_clr;
  logic               en_eff;
  logic               per_eff;
  logic               fire;

  logic               hit_tid;
  logic               hit_tcfg;
  logic               hit_tval;
  logic               hit_ticlr;
  logic [31:0]        tcfg_rd;
  logic [31:0]        tval_rd;

  // write decode and masked merge of the new register values
  always_comb begin
    tid_we    = csr_we && (csr_num == CSR_TID);
    tcfg_we   = csr_we && (csr_num == CSR_TCFG);
    ticlr_clr = csr_we && (csr_num == CSR_TICLR)
                && csr_wmask[0] && csr_wvalue[0];
    tid_new   = (csr_wmask & csr_wvalue)
                | (~csr_wmask & tid_q);
    tcfg_new  = (csr_wmask[TIMER_W-1:0]
                 & csr_wvalue[TIMER_W-1:0])
                | (~csr_wmask[TIMER_W-1:0] & tcfg_q);
  end

  // a same-cycle TCFG write decides En/Periodic/InitVal for the counter
  always_comb begin
    cfg_eff    = tcfg_we ? tcfg_new : tcfg_q;
    en_eff     = cfg_eff[0];
    per_eff    = cfg_eff[1];
    reload_val = {cfg_eff[TIMER_W-1:2], 2'b00};
  end

  // expiry is judged on the configuration and count of this cycle
  always_comb begin
    fire = tcfg_q[0] && (cnt_q == CNT_ZERO);
  end

  // counter next value: load on enabling write, else count or hold
  always_comb begin
    cnt_d = cnt_q;
    if (tcfg_we && en_eff) begin
      cnt_d = reload_val;
    end else if (en_eff && (cnt_q != CNT_ONES)) begin
      if ((cnt_q == CNT_ZERO) && per_eff) begin
        cnt_d = reload_val;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // interrupt next value: set beats a same-cycle clear
  always_comb begin
    int_d = int_q;
    if (fire) begin
      int_d = 1'b1;
    end else if (ticlr_clr) begin
      int_d = 1'b0;
    end
  end

  // TID register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tid_q <= CORE_ID;
    end else if (tid_we) begin
      tid_q <= tid_new;
    end
  end

  // TCFG register, only the implemented low bits are stored
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcfg_q <= CNT_ZERO;
    end else if (tcfg_we) begin
      tcfg_q <= tcfg_new;
    end
  end

  // countdown counter, idles at all-ones after reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= CNT_ONES;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // pending timer interrupt level
  always_ff @(posedge clk) begin
    if (!resetn) begin
      int_q <= 1'b0;
    end else begin
      int_q <= int_d;
    end
  end

  assign timer_int = int_q;

  // zero-extend the narrow fields to the 32-bit read bus
  always_comb begin
    tcfg_rd = '0;
    tval_rd = '0;
    tcfg_rd[TIMER_W-1:0] = tcfg_q;
    tval_rd[TIMER_W-1:0] = cnt_q;
  end

  // read address decode
  always_comb begin
    hit_tid   = (csr_raddr == CSR_TID);
    hit_tcfg  = (csr_raddr == CSR_TCFG);
    hit_tval  = (csr_raddr == CSR_TVAL);
    hit_ticlr = (csr_raddr == CSR_TICLR);
  end

  // read mux, zero for foreign addresses so the main mux can OR it in
  always_comb begin
    csr_rvalue = '0;
    unique case (1'b1)
      hit_tid:   csr_rvalue = tid_q;
      hit_tcfg:  csr_rvalue = tcfg_rd;
      hit_tval:  csr_rvalue = tval_rd;
      hit_ticlr: csr_rvalue = '0;
      default:   csr_rvalue = '0;
    endcase
  end

`ifdef TIMER_STABLE_CNT_EN
  logic [63:0] stable_q;

  // free-running stable counter for rdcntvl.w / rdcntvh.w
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stable_q <= 64'd0;
    end else begin
      stable_q <= stable_q + 64'd1;
    end
  end

  assign cnt_lo = stable_q[31:0];
  assign cnt_hi = stable_q[63:32];
`else
  assign cnt_lo = 32'd0;
  assign cnt_hi = 32'd0;
`endif

endmodule

// File: tb/tb_csr_timer.sv
// tb_csr_timer: directed bench for csr_timer with a cycle model
// and per-cycle comparison of read data, interrupt and stable counter.
module tb_csr_timer;

  localparam logic [31:0] CID = 32'h0000_0007;
  localparam logic [13:0] A_TID   = 14'h040;
  localparam logic [13:0] A_TCFG  = 14'h041;
  localparam logic [13:0] A_TVAL  = 14'h042;
  localparam logic [13:0] A_TICLR = 14'h044;
  localparam longint ALL = 64'hFFFF_FFFF;

  logic        clk;
  logic        resetn;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rvalue;
  logic        timer_int;
  logic [31:0] cnt_lo;
  logic [31:0] cnt_hi;

  int nchk = 0;
  int nerr = 0;

  csr_timer #(
    .CORE_ID(CID),
    .TIMER_W(32)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .csr_we(csr_we),
    .csr_num(csr_num),
    .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue),
    .csr_raddr(csr_raddr),
    .csr_rvalue(csr_rvalue),
    .timer_int(timer_int),
    .cnt_lo(cnt_lo),
    .cnt_hi(cnt_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [31:0] m_tid;
  logic [31:0] m_cfg;
  longint      m_cnt;
  logic        m_int;
  logic [63:0] m_stab;
  bit          m_ok = 1'b0;

  function automatic logic [31:0] m_read(input logic [13:0] a);
    if (a == A_TID) return m_tid;
    if (a == A_TCFG) return m_cfg;
    if (a == A_TVAL) return m_cnt[31:0];
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] nv;
    logic        fired;
    logic        clr;
    longint      ld;
    if (!resetn) begin
      m_tid  = CID;
      m_cfg  = 32'd0;
      m_cnt  = ALL;
      m_int  = 1'b0;
      m_stab = 64'd0;
      m_ok   = 1'b1;
    end else begin
      fired = m_cfg[0] && (m_cnt == 0);
      clr = csr_we && csr_num == A_TICLR
            && csr_wmask[0] && csr_wvalue[0];
      nv = m_cfg;
      if (csr_we && csr_num == A_TCFG)
        nv = (csr_wmask & csr_wvalue) | (~csr_wmask & m_cfg);
      ld = longint'(nv >> 2) * 4;
      if (csr_we && csr_num == A_TCFG && nv[0])
        m_cnt = ld;
      else if (nv[0] && m_cnt != ALL) begin
        if (m_cnt == 0) m_cnt = nv[1] ? ld : ALL;
        else m_cnt = m_cnt - 1;
      end
      if (csr_we && csr_num == A_TID)
        m_tid = (csr_wmask & csr_wvalue) | (~csr_wmask & m_tid);
      m_cfg = nv;
      if (fired) m_int = 1'b1;
      else if (clr) m_int = 1'b0;
      m_stab = m_stab + 64'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [63:0] es;
    if (m_ok) begin
`ifdef TIMER_STABLE_CNT_EN
      es = m_stab;
`else
      es = 64'd0;
`endif
      nchk = nchk + 3;
      if (csr_rvalue !== m_read(csr_raddr)) begin
        nerr = nerr + 1;
        $display("FAIL model_rd addr=%h: got %h expected %h",
                 csr_raddr, csr_rvalue, m_read(csr_raddr));
      end
      if (timer_int !== m_int) begin
        nerr = nerr + 1;
        $display("FAIL model_int: got %b expected %b",
                 timer_int, m_int);
      end
      if ({cnt_hi, cnt_lo} !== es) begin
        nerr = nerr + 1;
        $display("FAIL model_stab: got %h expected %h",
                 {cnt_hi, cnt_lo}, es);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] m,
                    input logic [31:0] v);
    csr_we     = 1'b1;
    csr_num    = a;
    csr_wmask  = m;
    csr_wvalue = v;
    tick();
    csr_we     = 1'b0;
    csr_wmask  = 32'd0;
    csr_wvalue = 32'd0;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk = nchk + 1;
    if (got !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [13:0] a,
                    input logic [31:0] exp);
    csr_raddr = a;
    #1;
    chk(nm, {32'd0, csr_rvalue}, {32'd0, exp});
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [63:0] exp_stab;
    resetn     = 1'b0;
    csr_we     = 1'b0;
    csr_num    = 14'd0;
    csr_wmask  = 32'd0;
    csr_wvalue = 32'd0;
    csr_raddr  = A_TVAL;
    repeat (3) tick();
    resetn = 1'b1;

    repeat (100) tick();
`ifdef TIMER_STABLE_CNT_EN
    exp_stab = 64'd100;
`else
    exp_stab = 64'd0;
`endif
    chk("stable_100", {cnt_hi, cnt_lo}, exp_stab);

    rd("rst_tid", A_TID, CID);
    tick();
    rd("rst_tcfg", A_TCFG, 32'd0);
    tick();
    rd("rst_tval", A_TVAL, 32'hFFFF_FFFF);
    tick();
    rd("rst_ticlr", A_TICLR, 32'd0);
    chk("rst_int", {63'd0, timer_int}, 64'd0);
    tick();
    rd("foreign_addr", 14'h005, 32'd0);

    wr(A_TID, 32'h0000_FFFF, 32'hABCD_1234);
    rd("tid_masked", A_TID, 32'h0000_1234);
    wr(A_TVAL, 32'hFFFF_FFFF, 32'd0);
    rd("tval_ro", A_TVAL, 32'hFFFF_FFFF);

    // one-shot countdown from 16
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
    for (int i = 16; i >= 0; i--) begin
      rd($sformatf("os_tval_%0d", i), A_TVAL, 32'(i));
      chk("os_int_low", {63'd0, timer_int}, 64'd0);
      tick();
    end
    chk("os_int_set", {63'd0, timer_int}, 64'd1);
    rd("os_wrap", A_TVAL, 32'hFFFF_FFFF);
    repeat (3) tick();
    rd("os_hold", A_TVAL, 32'hFFFF_FFFF);
    chk("os_int_hold", {63'd0, timer_int}, 64'd1);

    // clear with mask 0 is ignored, with mask 1 clears
    wr(A_TICLR, 32'd0, 32'd1);
    chk("clr_mask0", {63'd0, timer_int}, 64'd1);
    wr(A_TICLR, 32'd1, 32'd1);
    chk("clr_mask1", {63'd0, timer_int}, 64'd0);

    // periodic from 8, period 9
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
    for (int k = 0; k <= 18; k++) begin
      rd($sformatf("per_tval_%0d", k), A_TVAL, 32'(8 - (k % 9)));
      chk($sformatf("per_int_%0d", k), {63'd0, timer_int},
          (k == 9 || k == 18) ? 64'd1 : 64'd0);
      if (k == 9) wr(A_TICLR, 32'd1, 32'd1);
      else if (k < 18) tick();
    end

    // clear, run down to 0, then collide clear with set
    wr(A_TICLR, 32'd1, 32'd1);
    chk("pre_coll_int", {63'd0, timer_int}, 64'd0);
    repeat (7) tick();
    rd("coll_tval0", A_TVAL, 32'd0);
    wr(A_TICLR, 32'd1, 32'd1);
    chk("coll_int", {63'd0, timer_int}, 64'd1);
    rd("coll_reload", A_TVAL, 32'd8);

    // freeze at 5 by clearing En
    repeat (3) tick();
    rd("frz_pre", A_TVAL, 32'd5);
    wr(A_TCFG, 32'h0000_0001, 32'd0);
    rd("frz_now", A_TVAL, 32'd5);
    repeat (3) tick();
    rd("frz_hold", A_TVAL, 32'd5);
    rd("frz_tcfg", A_TCFG, 32'h0000_000A);

    // InitVal 0 periodic: interrupt every cycle
    wr(A_TICLR, 32'd1, 32'd1);
    chk("z_clr", {63'd0, timer_int}, 64'd0);
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0003);
    rd("z_tval", A_TVAL, 32'd0);
    tick();
    chk("z_int", {63'd0, timer_int}, 64'd1);
    wr(A_TICLR, 32'd1, 32'd1);
    chk("z_int_again", {63'd0, timer_int}, 64'd1);

    // reset mid-countdown
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
    repeat (2) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rd("mr_tval", A_TVAL, 32'hFFFF_FFFF);
    chk("mr_int", {63'd0, timer_int}, 64'd0);
    tick();
    rd("mr_tcfg", A_TCFG, 32'd0);
    tick();
    rd("mr_tid", A_TID, CID);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/csr_timer.md
Name: csr_timer

Overview:
- Timer/interrupt-source unit for the LoongArch CSR file; sits directly upstream of the main CSR module.
- Owns TID (0x040), TCFG (0x041), TVAL (0x042) and TICLR (0x044), and runs the countdown timer.
- Produces the level timer interrupt consumed as ESTAT.IS[11].
- Shares the CSR write bus; returns a read value that the main CSR read mux ORs in.

Parameters:
- CORE_ID, 32'h0: reset value of TID.
- TIMER_W, 32: timer width n, legal range 8..32. TCFG.InitVal occupies [TIMER_W-1:2].

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- csr_we  input  1  CSR write enable
- csr_num  input  14  CSR write address
- csr_wmask  input  32  bit write mask
- csr_wvalue  input  32  write data
- csr_raddr  input  14  CSR read address
- csr_rvalue  output  32  read data; 0 when csr_raddr is not one of this block's registers
- timer_int  output  1  timer interrupt pending (ESTAT.IS[11])
- cnt_lo  output  32  stable counter [31:0]
- cnt_hi  output  32  stable counter [63:32]

Behaviour:
- Register writes: every write is masked, new = wmask&wvalue | ~wmask&old, and takes effect at the next clk edge.
- TID: reset CORE_ID; fully writable.
- TCFG: reset 0. Fields: En[0], Periodic[1], InitVal[TIMER_W-1:2]. Bits [31:TIMER_W] read 0 and ignore writes.
- timer_cnt (TIMER_W bits) reset value: all ones.
- timer_cnt update priority, highest first:
  1. TCFG write whose resulting En=1: load {new InitVal, 2'b00}.
  2. En=1 and timer_cnt != all-ones:
     - timer_cnt==0 and Periodic=1: reload {InitVal,2'b00}.
     - otherwise: decrement by 1. One-shot therefore wraps 0 -> all-ones and then holds.
  3. Otherwise: hold.
- En cleared by a write: timer_cnt freezes at its current value.
- TVAL: read-only, returns zero-extended timer_cnt. Writes are ignored.
- TICLR: reads 0. Writing with wmask[0]&wvalue[0]=1 clears timer_int; all other bits are ignored.
- timer_int: reset 0.
  - Set on the cycle after a cycle where En=1 and timer_cnt==0.
  - Set has priority over a same-cycle TICLR clear.
  - Otherwise holds until cleared.
- InitVal=0 with Periodic=1: counter sits at 0 and timer_int is re-asserted every cycle.
- Read path: purely combinational, zero latency. csr_rvalue is 0 for any other address.
- Reset mid-countdown: all state returns to reset values on the next edge; a pending interrupt is lost.
- Outputs have no dependence on csr_raddr except csr_rvalue.

Optional Feature:
- Macro: TIMER_STABLE_CNT_EN.
- Defined:
  - 64-bit stable counter, reset 0, increments by 1 every cycle, wraps to 0 after all-ones.
  - cnt_lo/cnt_hi expose the registered value, for rdcntvl.w/rdcntvh.w.
- Undefined: no counter flops; cnt_lo and cnt_hi are tied to 0.

Test Plan:
- Reset, then read 0x040/0x041/0x042/0x044 -> CORE_ID, 0, 32'hFFFFFFFF, 0; timer_int=0.
- One-shot: write TCFG=32'h0000_0011 (InitVal=4, cnt=16, En=1, Periodic=0) -> TVAL reads 16,15,...,0 on consecutive cycles; timer_int rises 1 cycle after cnt=0; TVAL then reads FFFFFFFF and holds; timer_int stays 1.
- Clear: with timer_int=1, write TICLR wvalue=1, wmask=1 -> timer_int=0 next cycle. Same write with wmask=0 -> no change.
- Periodic: TCFG=32'h0000_000B (cnt=8, En=1, Periodic=1) -> timer_int set every 9 cycles. Clear after the first expiry and check it reasserts at the next expiry; TVAL sequence 8..0,8..0.
- Collision and freeze:
  - TICLR clear issued the same cycle the set condition fires -> timer_int stays 1.
  - TCFG write with En=0 mid-count (cnt=5) -> TVAL holds 5.
- With TIMER_STABLE_CNT_EN: 100 cycles after reset, {cnt_hi,cnt_lo}=100. Without the macro, both stay 0.
